// File: rtl/datapath_run_controller.sv
// Execution sequencer for the single-cycle RISC-V datapath: gates per-cycle
// retirement, drives datapath reset, and reports stop cause and retire count.
module datapath_run_controller #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned COUNT_WIDTH = 16,
  parameter logic [31:0] HALT_INSTR  = 32'h00000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [COUNT_WIDTH-1:0] step_count,
  input  logic                   bp_enable,
  input  logic [PC_WIDTH-1:0]    bp_addr,
  input  logic [PC_WIDTH-1:0]    pc,
  input  logic [31:0]            instruction,
  output logic                   dp_enable,
  output logic                   dp_reset,
  output logic [1:0]             state,
  output logic [COUNT_WIDTH-1:0] cycles_retired,
  output logic [1:0]             halt_cause,
  output logic                   done
);

  localparam logic [1:0] ST_INIT = 2'b00;
  localparam logic [1:0] ST_IDLE = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;
  localparam logic [1:0] ST_STEP = 2'b11;

  localparam logic [1:0] OP_RESTART = 2'b00;
  localparam logic [1:0] OP_RUN     = 2'b01;
  localparam logic [1:0] OP_STEP    = 2'b10;
  localparam logic [1:0] OP_HALT    = 2'b11;

  localparam logic [1:0] CAUSE_HOST  = 2'd0;
  localparam logic [1:0] CAUSE_STEPS = 2'd1;
  localparam logic [1:0] CAUSE_HALT  = 2'd2;
  localparam logic [1:0] CAUSE_BP    = 2'd3;

  logic [1:0]             state_q;
  logic                   first_q;
  logic [COUNT_WIDTH-1:0] remaining_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [1:0]             cause_q;
  logic                   done_q;

  logic       active;
  logic       accept;
  logic       hi;
  logic       bp;
  logic       host_halt;
  logic       steps_out;
  logic       stop;
  logic       zero_step;
  logic [1:0] stop_cause;

  assign state          = state_q;
  assign cycles_retired = count_q;
  assign halt_cause     = cause_q;
  assign done           = done_q;

  always_comb begin
    active    = (state_q == ST_RUN) || (state_q == ST_STEP);
    cmd_ready = (state_q != ST_INIT);
    dp_reset  = (state_q == ST_INIT);
    accept    = cmd_valid & cmd_ready;
    hi        = (instruction == HALT_INSTR);
    // first suppresses the breakpoint so a resume can leave a breakpoint PC
    bp        = bp_enable & (pc == bp_addr) & ~first_q;
    dp_enable = active & ~hi & ~bp;
    // a host halt leaves dp_enable alone: the current instruction still retires
    host_halt = active & accept & (cmd_op == OP_HALT);
    steps_out = (state_q == ST_STEP) & (remaining_q == COUNT_WIDTH'(1)) & dp_enable;
    stop      = active & (hi | bp | host_halt | steps_out);
    zero_step = (state_q == ST_IDLE) & accept & (cmd_op == OP_STEP) &
                (step_count == '0);

    if (hi)             stop_cause = CAUSE_HALT;
    else if (bp)        stop_cause = CAUSE_BP;
    else if (host_halt) stop_cause = CAUSE_HOST;
    else                stop_cause = CAUSE_STEPS;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      first_q     <= 1'b0;
      remaining_q <= '0;
      count_q     <= '0;
      cause_q     <= CAUSE_HOST;
      done_q      <= 1'b0;
    end else begin
      done_q <= stop | zero_step;
      if (zero_step)
        cause_q <= CAUSE_STEPS;
      else if (stop)
        cause_q <= stop_cause;

      if (dp_enable && (count_q != '1))
        count_q <= count_q + COUNT_WIDTH'(1);

      case (state_q)
        ST_INIT: state_q <= ST_IDLE;
        ST_IDLE: begin
          if (accept) begin
            case (cmd_op)
              OP_RESTART: begin
                state_q <= ST_INIT;
                count_q <= '0;
              end
              OP_RUN: begin
                state_q <= ST_RUN;
                first_q <= 1'b1;
              end
              OP_STEP: begin
                if (step_count != '0) begin
                  state_q     <= ST_STEP;
                  remaining_q <= step_count;
                  first_q     <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        default: begin
          first_q <= 1'b0;
          if ((state_q == ST_STEP) && dp_enable)
            remaining_q <= remaining_q - COUNT_WIDTH'(1);
          if (stop)
            state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_run_controller.sv
// Scoreboard bench for datapath_run_controller: a toy datapath/instruction memory
// feeds the controller; a program-level model predicts each stop.
module tb_datapath_run_controller;

  localparam int unsigned CW    = 6;
  localparam int unsigned CMAX  = (1 << CW) - 1;
  localparam logic [31:0] HI    = 32'h00000000;

  localparam logic [1:0] OP_RESTART = 2'b00;
  localparam logic [1:0] OP_RUN     = 2'b01;
  localparam logic [1:0] OP_STEP    = 2'b10;
  localparam logic [1:0] OP_HALT    = 2'b11;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [CW-1:0] step_count = '0;
  logic          bp_enable = 1'b0;
  logic [31:0]   bp_addr = '0;
  logic [31:0]   pc = '0;
  logic [31:0]   instruction;
  logic          dp_enable;
  logic          dp_reset;
  logic [1:0]    state;
  logic [CW-1:0] cycles_retired;
  logic [1:0]    halt_cause;
  logic          done;

  always #5 clock = ~clock;

  datapath_run_controller #(
    .PC_WIDTH   (32),
    .COUNT_WIDTH(CW),
    .HALT_INSTR (HI)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .step_count    (step_count),
    .bp_enable     (bp_enable),
    .bp_addr       (bp_addr),
    .pc            (pc),
    .instruction   (instruction),
    .dp_enable     (dp_enable),
    .dp_reset      (dp_reset),
    .state         (state),
    .cycles_retired(cycles_retired),
    .halt_cause    (halt_cause),
    .done          (done)
  );

  // Toy datapath: program counter plus 64-word instruction memory.
  logic [31:0] imem [64];
  assign instruction = imem[pc[7:2]];

  always @(posedge clock) begin
    if (dp_reset)       pc <= '0;
    else if (dp_enable) pc <= pc + 32'd4;
  end

  typedef struct {
    logic [1:0]  cause;
    int unsigned count;
    int unsigned pcv;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned mpc = 0;
  int unsigned mcount = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  task automatic push(input logic [1:0] cause, input int unsigned count, input int unsigned pcv);
    exp_t e;
    e.cause = cause;
    e.count = count;
    e.pcv   = pcv;
    exp_q.push_back(e);
  endtask

  // Walks the program word by word from the current PC to find where it stops.
  task automatic predict(input logic [1:0] op, input int unsigned n);
    int unsigned k = 0;
    bit          stopped = 0;
    logic [1:0]  cause = 2'd0;
    logic [5:0]  idx;
    if (op == OP_STEP && n == 0) begin
      push(2'd1, mcount, mpc);
      return;
    end
    while (!stopped && k < 1000) begin
      idx = 6'((mpc >> 2) & 63);
      if (imem[idx] == HI) begin
        cause = 2'd2; stopped = 1;
      end else if (bp_enable && (mpc == bp_addr) && k > 0) begin
        cause = 2'd3; stopped = 1;
      end else begin
        if (mcount < CMAX) mcount++;
        mpc += 4;
        k++;
        if (op == OP_STEP && k == n) begin
          cause = 2'd1; stopped = 1;
        end
      end
    end
    push(cause, mcount, mpc);
  endtask

  always @(negedge clock) begin
    if (reset && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("halt_cause", 64'(halt_cause), 64'(e.cause));
        chk("cycles_retired", 64'(cycles_retired), 64'(e.count));
        chk("stop_pc", 64'(pc), 64'(e.pcv));
        chk("state_after_stop", 64'(state), 64'd1);
      end
    end
  end

  task automatic send(input logic [1:0] op, input int unsigned n);
    @(negedge clock);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    step_count = CW'(n);
    @(negedge clock);
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned limit);
    int unsigned c = 0;
    while (exp_q.size() != 0 && c < limit) begin
      @(negedge clock);
      c++;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic fill_imem(input bit random_halts);
    for (int i = 0; i < 63; i++)
      imem[i] = (random_halts && $urandom_range(0, 7) == 0) ? HI : ($urandom | 32'h13);
    imem[63] = HI;
  endtask

  task automatic release_check();
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("dp_reset_after_release", 64'(dp_reset), 64'd1);
    chk("ready_in_init", 64'(cmd_ready), 64'd0);
    chk("state_init", 64'(state), 64'd0);
    @(negedge clock);
    chk("dp_reset_cleared", 64'(dp_reset), 64'd0);
    chk("state_idle", 64'(state), 64'd1);
    chk("ready_in_idle", 64'(cmd_ready), 64'd1);
    chk("count_after_reset", 64'(cycles_retired), 64'd0);
    chk("cause_after_reset", 64'(halt_cause), 64'd0);
    mpc = 0;
    mcount = 0;
  endtask

  task automatic restart();
    send(OP_RESTART, 0);
    chk("restart_dp_reset", 64'(dp_reset), 64'd1);
    @(negedge clock);
    chk("restart_idle", 64'(state), 64'd1);
    chk("restart_count", 64'(cycles_retired), 64'd0);
    chk("restart_pc", 64'(pc), 64'd0);
    mpc = 0;
    mcount = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned r;
    logic [1:0]  op;
    int unsigned n;

    fill_imem(1'b0);
    repeat (3) @(negedge clock);
    chk("reset_dp_enable", 64'(dp_enable), 64'd0);
    chk("reset_dp_reset", 64'(dp_reset), 64'd1);
    chk("reset_done", 64'(done), 64'd0);
    release_check();

    // 1: RESTART from IDLE
    restart();

    // 2: STEP 3 over plain instructions
    push(2'd1, 3, 12);
    send(OP_STEP, 3);
    wait_idle(50);

    // 3: RUN to a halt instruction at pc=16; RESTART mid-run is ignored
    imem[4] = HI;
    restart();
    push(2'd2, 4, 16);
    send(OP_RUN, 0);
    send(OP_RESTART, 0);
    wait_idle(50);
    push(2'd2, 4, 16);
    send(OP_RUN, 0);
    wait_idle(50);
    imem[4] = 32'h00000013;

    // 4: breakpoint at 8, then resume off it with STEP 1
    restart();
    bp_enable = 1'b1;
    bp_addr   = 32'd8;
    push(2'd3, 2, 8);
    send(OP_RUN, 0);
    wait_idle(50);
    push(2'd1, 3, 12);
    send(OP_STEP, 1);
    wait_idle(50);
    bp_enable = 1'b0;

    // 5: host HALT lands on the last STEP instruction
    push(2'd0, 6, 24);
    send(OP_STEP, 3);
    @(negedge clock);
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = OP_HALT;
    @(negedge clock);
    cmd_valid = 1'b0;
    wait_idle(50);
    repeat (2) @(negedge clock);

    // cycles_retired saturation with no halt word in the way
    imem[63] = 32'h00000013;
    restart();
    predict(OP_STEP, 40);
    send(OP_STEP, 40);
    wait_idle(100);
    predict(OP_STEP, 30);
    send(OP_STEP, 30);
    wait_idle(100);
    imem[63] = HI;

    // 6: asynchronous reset in the middle of a RUN
    restart();
    send(OP_RUN, 0);
    repeat (2) @(negedge clock);
    chk("running_before_reset", 64'(dp_enable), 64'd1);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("async_dp_enable", 64'(dp_enable), 64'd0);
    chk("async_dp_reset", 64'(dp_reset), 64'd1);
    chk("async_count", 64'(cycles_retired), 64'd0);
    chk("async_state", 64'(state), 64'd0);
    exp_q.delete();
    @(negedge clock);
    chk("reset_no_done", 64'(done), 64'd0);
    release_check();
    restart();

    // Randomized command stream against the program-level model
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        send(OP_HALT, 0);
        @(negedge clock);
        chk("idle_halt_ignored", 64'(state), 64'd1);
      end else if (r == 1) begin
        fill_imem(1'b1);
        restart();
      end else begin
        bp_enable = ($urandom_range(0, 2) == 0);
        bp_addr   = 32'($urandom_range(0, 15) * 4);
        op        = (r < 6) ? OP_RUN : OP_STEP;
        n         = $urandom_range(0, 12);
        predict(op, n);
        send(op, n);
        wait_idle(300);
      end
    end

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/datapath_run_controller.md
Name: datapath_run_controller

Overview:
Execution sequencer for the single-cycle RISC-V Datapath. It gates the datapath's advance with a per-cycle enable and drives the datapath's reset. A host or testbench controls it through a valid/ready command port with RESTART, RUN, STEP-N and HALT operations. It stops execution on a halt instruction, a PC breakpoint, step exhaustion or a host HALT, and reports the cause plus a retired-instruction count.

Parameters:
PC_WIDTH, 32, width of pc and bp_addr
COUNT_WIDTH, 16, width of step_count, remaining-step counter and cycles_retired
HALT_INSTR, 32'h00000000, instruction encoding that marks end of program

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller accepts command this cycle
cmd_op  input  2  00 RESTART, 01 RUN, 10 STEP, 11 HALT
step_count  input  COUNT_WIDTH  instruction count for STEP, sampled on accept
bp_enable  input  1  breakpoint armed
bp_addr  input  PC_WIDTH  breakpoint PC
pc  input  PC_WIDTH  current datapath PC
instruction  input  32  instruction currently fetched by datapath
dp_enable  output  1  datapath retires current instruction at next rising edge
dp_reset  output  1  active-high reset to datapath
state  output  2  00 INIT, 01 IDLE, 10 RUN, 11 STEP
cycles_retired  output  COUNT_WIDTH  instructions retired since last reset/RESTART
halt_cause  output  2  0 HOST, 1 STEPS, 2 HALT_INSTR, 3 BREAKPOINT
done  output  1  one-cycle pulse on stop

Behaviour:
- Reset low (async, any time, including mid-RUN): state=INIT, dp_reset=1, dp_enable=0 immediately, cmd_ready=0, done=0, cycles_retired=0, halt_cause=0, remaining=0, first=0.
- INIT: dp_reset=1 and cmd_ready=0. After the first rising edge with reset high, go to IDLE. dp_reset is high exactly one cycle after release.
- Accept = cmd_valid & cmd_ready at a rising edge. cmd_ready=1 in IDLE, RUN and STEP; cmd_ready=0 in INIT.
- IDLE, dp_enable=0:
  - RESTART -> INIT; cycles_retired cleared.
  - RUN -> RUN; first set to 1.
  - STEP with N>0 -> STEP; remaining=N; first set to 1.
  - STEP with N=0 -> stay IDLE; done pulses next cycle with halt_cause=STEPS.
  - HALT -> ignored, no done.
- RUN/STEP, combinational stop checks:
  - hi = (instruction==HALT_INSTR).
  - bp = bp_enable & (pc==bp_addr) & ~first.
  - dp_enable = ~hi & ~bp.
  - The first flag lets execution resume off a breakpoint PC; it clears after the first cycle in RUN/STEP.
- Each cycle with dp_enable=1: cycles_retired increments, saturating at all-ones. In STEP, remaining also decrements.
- Stop -> IDLE at the edge. Priority when several apply:
  1. hi -> cause HALT_INSTR.
  2. bp -> cause BREAKPOINT.
  3. accepted HALT -> cause HOST.
  4. STEP with remaining==1 and dp_enable -> cause STEPS.
- A HOST halt does not suppress dp_enable in its cycle, so that instruction still retires.
- RUN/RESTART/STEP accepted while in RUN or STEP are consumed and ignored.
- done: registered, high exactly in the first IDLE cycle after a stop. halt_cause updates on the same edge and holds until the next stop.
- Entering IDLE from INIT produces no done.

Test Plan:
1. Reset release, RESTART -> dp_reset high exactly 1 cycle after release; IDLE with cmd_ready=1; cycles_retired=0; no done.
2. STEP N=3, non-halt instructions, pc=0,4,8 -> dp_enable high 3 consecutive cycles; IDLE with done pulse; halt_cause=1; cycles_retired=3.
3. RUN with HALT_INSTR at pc=16 (5th instruction) -> 4 instructions retire; dp_enable=0 at pc=16; halt_cause=2; done; cycles_retired=4. A second RUN stops immediately with cycles_retired unchanged.
4. Breakpoint bp_addr=8 -> RUN stops with pc=8, halt_cause=3, cycles_retired=2. STEP N=1 then retires pc=8 (first-cycle skip) and stops with cause 1.
5. HALT accepted in the same cycle as the last STEP instruction -> that instruction retires; halt_cause=0 (HOST beats STEPS); single done pulse.
6. Reset asserted mid-RUN -> dp_enable=0 and dp_reset=1 same cycle (async); cycles_retired=0; no done. After release, the sequence resumes per scenario 1.
